vx_l1_mem_merge: RTL and testbench
==================================

VX_L1_MEM_MERGE -- requirements
Module: VX_l1_mem_merge

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, line size in bytes.
REQ-002 SHALL have parameter ADDR_WIDTH, default 26, line address width.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, per-source request tag width.
REQ-004 SHALL have parameter MAX_PENDING, default 16, maximum outstanding memory reads.
REQ-005 SHALL have parameter STARVE_LIMIT, default 4, consecutive dcache denials before dcache is forced.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port icache_req_valid/addr/tag, input, 1/ADDR_WIDTH/TAG_WIDTH, icache read request.
REQ-009 SHALL have port icache_req_ready, output, 1, icache request accepted.
REQ-010 SHALL have port dcache_req_valid/rw/addr/data/byteen/tag, input, 1/1/ADDR_WIDTH/8*DATA_SIZE/DATA_SIZE/TAG_WIDTH, dcache request.
REQ-011 SHALL have port dcache_req_ready, output, 1, dcache request accepted.
REQ-012 SHALL have port mem_req_valid/rw/addr/data/byteen/tag, output, widths as REQ-010 with tag TAG_WIDTH+1, merged request.
REQ-013 SHALL have port mem_req_ready, input, 1, downstream accepts.
REQ-014 SHALL have port mem_rsp_valid/data/tag, input, 1/8*DATA_SIZE/TAG_WIDTH+1, memory read response.
REQ-015 SHALL have port mem_rsp_ready, output, 1, response consumed.
REQ-016 SHALL have ports {icache,dcache}_rsp_valid/data/tag (outputs, 1/8*DATA_SIZE/TAG_WIDTH) and {icache,dcache}_rsp_ready (inputs, 1), the per-source responses.

Function
REQ-017 SHALL hold one output pipe register; a request is accepted when the register is empty or drains (mem_req_valid & mem_req_ready) in the same cycle; request-to-mem_req_valid latency is 1 cycle; full throughput of 1 request/cycle.
REQ-018 SHALL forward tag {source, input_tag}, source 0 = icache, 1 = dcache; icache requests SHALL carry rw=0, byteen all-ones, and data zero.
REQ-019 SHALL grant the icache when both sources are valid, unless starve_cnt == STARVE_LIMIT, in which case the dcache is granted.
REQ-020 SHALL increment starve_cnt when dcache is valid and icache is granted; clear it on a dcache grant or when dcache_req_valid=0; it SHALL saturate at STARVE_LIMIT.
REQ-021 SHALL keep a pending counter: +1 per accepted read, -1 per mem_rsp handshake; a simultaneous +1/-1 SHALL leave it unchanged.
REQ-022 SHALL, with pending == MAX_PENDING, refuse reads (ready=0) while still accepting dcache writes; a stall SHALL NOT advance starve_cnt.
REQ-023 SHALL route responses combinationally by tag MSB, strip the MSB, and set mem_rsp_ready to the selected sink's ready.
REQ-024 SHALL NOT change the registered request while mem_req_valid=1 and mem_req_ready=0.

Reset
REQ-025 SHALL on reset assert mem_req_valid=0, pending=0, starve_cnt=0, and clear the perf counters; response outputs follow inputs; an in-flight request in the register is dropped.

Configuration
REQ-026 SHALL, with L1_MERGE_PERF_EN defined, add 32-bit outputs perf_icache_stalls/perf_dcache_stalls, each counting cycles with the source valid and not ready and wrapping at 2^32; without it, these ports and their logic SHALL be absent.

Verification
REQ-027 Both sources valid every cycle, mem_req_ready=1 -> grant pattern I,I,I,I,D repeating (STARVE_LIMIT=4).
REQ-028 16 icache reads with no responses -> 17th read held with ready=0; a dcache write in the same cycle is accepted; one response -> read accepted next cycle.
REQ-029 mem_req_ready=0 for 5 cycles with the register full -> mem_req_* stable and both readies 0; ready=1 -> drain, and a new request is accepted in the same cycle.
REQ-030 mem_rsp tag 0x105 with dcache_rsp_ready=0 -> dcache_rsp_valid=1, tag 0x05, mem_rsp_ready=0; icache_rsp_valid=0.
REQ-031 Reset asserted mid-stream with pending=7 -> mem_req_valid=0 and pending=0 immediately, without waiting for a clock edge.
REQ-032 With L1_MERGE_PERF_EN: icache blocked 3 cycles by a full register -> perf_icache_stalls=3.

Source files
------------

// File: rtl/vx_l1_mem_merge_if.sv
// ---------------------------------------------------------------------------
// vx_l1_mem_merge_if
// Bundles every request/response channel of the L1 memory merge unit:
//   icache_req_*  : icache read request (valid/addr/tag, ready back)
//   dcache_req_*  : dcache request (valid/rw/addr/data/byteen/tag, ready back)
//   mem_req_*     : merged request to memory, tag = {source, input_tag}
//   mem_rsp_*     : memory read response, tag MSB selects the sink
//   icache_rsp_*  : icache response (valid/data/tag, ready from sink)
//   dcache_rsp_*  : dcache response (valid/data/tag, ready from sink)
// Modports: slave = the merge unit, master = the surrounding system/bench.
// ---------------------------------------------------------------------------
interface vx_l1_mem_merge_if #(
    parameter int DATA_SIZE  = 64,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 8
);
    logic                     icache_req_valid;
    logic [ADDR_WIDTH-1:0]    icache_req_addr;
    logic [TAG_WIDTH-1:0]     icache_req_tag;
    logic                     icache_req_ready;

    logic                     dcache_req_valid;
    logic                     dcache_req_rw;
    logic [ADDR_WIDTH-1:0]    dcache_req_addr;
    logic [8*DATA_SIZE-1:0]   dcache_req_data;
    logic [DATA_SIZE-1:0]     dcache_req_byteen;
    logic [TAG_WIDTH-1:0]     dcache_req_tag;
    logic                     dcache_req_ready;

    logic                     mem_req_valid;
    logic                     mem_req_rw;
    logic [ADDR_WIDTH-1:0]    mem_req_addr;
    logic [8*DATA_SIZE-1:0]   mem_req_data;
    logic [DATA_SIZE-1:0]     mem_req_byteen;
    logic [TAG_WIDTH:0]       mem_req_tag;
    logic                     mem_req_ready;

    logic                     mem_rsp_valid;
    logic [8*DATA_SIZE-1:0]   mem_rsp_data;
    logic [TAG_WIDTH:0]       mem_rsp_tag;
    logic                     mem_rsp_ready;

    logic                     icache_rsp_valid;
    logic [8*DATA_SIZE-1:0]   icache_rsp_data;
    logic [TAG_WIDTH-1:0]     icache_rsp_tag;
    logic                     icache_rsp_ready;

    logic                     dcache_rsp_valid;
    logic [8*DATA_SIZE-1:0]   dcache_rsp_data;
    logic [TAG_WIDTH-1:0]     dcache_rsp_tag;
    logic                     dcache_rsp_ready;

    modport slave (
        input  icache_req_valid, icache_req_addr, icache_req_tag,
        output icache_req_ready,
        input  dcache_req_valid, dcache_req_rw, dcache_req_addr, dcache_req_data,
        input  dcache_req_byteen, dcache_req_tag,
        output dcache_req_ready,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        output mem_req_byteen, mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready,
        output icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
        input  icache_rsp_ready,
        output dcache_rsp_valid, dcache_rsp_data, dcache_rsp_tag,
        input  dcache_rsp_ready
    );

    modport master (
        output icache_req_valid, icache_req_addr, icache_req_tag,
        input  icache_req_ready,
        output dcache_req_valid, dcache_req_rw, dcache_req_addr, dcache_req_data,
        output dcache_req_byteen, dcache_req_tag,
        input  dcache_req_ready,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        input  mem_req_byteen, mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready,
        input  icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
        output icache_rsp_ready,
        input  dcache_rsp_valid, dcache_rsp_data, dcache_rsp_tag,
        output dcache_rsp_ready
    );
endinterface

// File: rtl/vx_l1_mem_merge.sv
// ---------------------------------------------------------------------------
// vx_l1_mem_merge
// Merges icache and dcache request streams onto one memory port through a
// single output pipe register, and routes read responses back by tag MSB
// (0 = icache, 1 = dcache).
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : vx_l1_mem_merge_if.slave, all request/response channels
//   perf_icache_stalls / perf_dcache_stalls (only with L1_MERGE_PERF_EN):
//            32-bit wrapping counts of cycles a source is valid but not ready
// Optional feature macro: L1_MERGE_PERF_EN
// ---------------------------------------------------------------------------
module vx_l1_mem_merge #(
    parameter int DATA_SIZE    = 64,
    parameter int ADDR_WIDTH   = 26,
    parameter int TAG_WIDTH    = 8,
    parameter int MAX_PENDING  = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    vx_l1_mem_merge_if.slave    bus
`ifdef L1_MERGE_PERF_EN
    ,
    output logic [31:0]         perf_icache_stalls,
    output logic [31:0]         perf_dcache_stalls
`endif
);
    localparam int DW = 8 * DATA_SIZE;
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic                    req_valid_q, req_valid_d;
    logic                    req_rw_q, req_rw_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [DW-1:0]           req_data_q, req_data_d;
    logic [DATA_SIZE-1:0]    req_byteen_q, req_byteen_d;
    logic [TAG_WIDTH:0]      req_tag_q, req_tag_d;
    logic [PW-1:0]           pending_q, pending_d;
    logic [SW-1:0]           starve_q, starve_d;

    logic can_accept, rd_full, i_elig, d_elig, force_d;
    logic grant_i, grant_d, acc_i, acc_d, load, rd_inc, rsp_dec;

    always_comb begin
        // The register can take a new request if empty or draining this cycle.
        can_accept = ~req_valid_q | bus.mem_req_ready;
        rd_full    = (pending_q == PW'(MAX_PENDING));
        // With the read budget exhausted only dcache writes stay eligible.
        i_elig     = bus.icache_req_valid & ~rd_full;
        d_elig     = bus.dcache_req_valid & (bus.dcache_req_rw | ~rd_full);
        force_d    = (starve_q == SW'(STARVE_LIMIT));
        grant_d    = d_elig & (~i_elig | force_d);
        grant_i    = i_elig & ~grant_d;
        acc_i      = can_accept & grant_i;
        acc_d      = can_accept & grant_d;
        load       = acc_i | acc_d;

        req_valid_d  = load | (req_valid_q & ~bus.mem_req_ready);
        req_rw_d     = acc_d & bus.dcache_req_rw;
        req_addr_d   = acc_d ? bus.dcache_req_addr : bus.icache_req_addr;
        req_data_d   = acc_d ? bus.dcache_req_data : '0;
        req_byteen_d = acc_d ? bus.dcache_req_byteen : '1;
        req_tag_d    = acc_d ? {1'b1, bus.dcache_req_tag} : {1'b0, bus.icache_req_tag};

        // Starvation only counts real icache wins; stalled cycles hold it.
        starve_d = starve_q;
        if (acc_d || !bus.dcache_req_valid)
            starve_d = '0;
        else if (acc_i && !force_d)
            starve_d = starve_q + SW'(1);

        rd_inc    = load & ~req_rw_d;
        rsp_dec   = bus.mem_rsp_valid & bus.mem_rsp_ready;
        pending_d = pending_q;
        if (rd_inc && !rsp_dec)
            pending_d = pending_q + PW'(1);
        else if (!rd_inc && rsp_dec)
            pending_d = pending_q - PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_valid_q <= 1'b0;
            pending_q   <= '0;
            starve_q    <= '0;
        end else begin
            req_valid_q <= req_valid_d;
            pending_q   <= pending_d;
            starve_q    <= starve_d;
        end
    end

    // Payload needs no reset: it is qualified by req_valid_q.
    always_ff @(posedge clk) begin
        if (load) begin
            req_rw_q     <= req_rw_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            req_byteen_q <= req_byteen_d;
            req_tag_q    <= req_tag_d;
        end
    end

    assign bus.icache_req_ready = acc_i;
    assign bus.dcache_req_ready = acc_d;
    assign bus.mem_req_valid    = req_valid_q;
    assign bus.mem_req_rw       = req_rw_q;
    assign bus.mem_req_addr     = req_addr_q;
    assign bus.mem_req_data     = req_data_q;
    assign bus.mem_req_byteen   = req_byteen_q;
    assign bus.mem_req_tag      = req_tag_q;

    // Response path is purely combinational: the tag MSB picks the sink.
    assign bus.icache_rsp_valid = bus.mem_rsp_valid & ~bus.mem_rsp_tag[TAG_WIDTH];
    assign bus.dcache_rsp_valid = bus.mem_rsp_valid &  bus.mem_rsp_tag[TAG_WIDTH];
    assign bus.icache_rsp_data  = bus.mem_rsp_data;
    assign bus.dcache_rsp_data  = bus.mem_rsp_data;
    assign bus.icache_rsp_tag   = bus.mem_rsp_tag[TAG_WIDTH-1:0];
    assign bus.dcache_rsp_tag   = bus.mem_rsp_tag[TAG_WIDTH-1:0];
    assign bus.mem_rsp_ready    = bus.mem_rsp_tag[TAG_WIDTH] ? bus.dcache_rsp_ready
                                                             : bus.icache_rsp_ready;

`ifdef L1_MERGE_PERF_EN
    logic [31:0] perf_i_q, perf_d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_i_q <= '0;
            perf_d_q <= '0;
        end else begin
            if (bus.icache_req_valid && !acc_i) perf_i_q <= perf_i_q + 32'd1;
            if (bus.dcache_req_valid && !acc_d) perf_d_q <= perf_d_q + 32'd1;
        end
    end

    assign perf_icache_stalls = perf_i_q;
    assign perf_dcache_stalls = perf_d_q;
`endif
endmodule

// File: tb/tb_vx_l1_mem_merge.sv
module tb_vx_l1_mem_merge;
    localparam int DATA_SIZE = 64;
    localparam int ADDR_WIDTH = 26;
    localparam int TAG_WIDTH = 8;

    localparam logic [25:0]  IADDR = 26'h0012345;
    localparam logic [25:0]  DADDR = 26'h02ABCDE;
    localparam logic [7:0]   ITAG  = 8'h3C;
    localparam logic [7:0]   DTAG  = 8'hA5;
    localparam logic [511:0] DDATA = {8{64'hDEADBEEF_01234567}};
    localparam logic [63:0]  DBE   = 64'h00FF_0F0F_F0F0_FF00;
    localparam logic [511:0] RDATA = {16{32'hC0FFEE11}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vx_l1_mem_merge_if #(.DATA_SIZE(DATA_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .TAG_WIDTH(TAG_WIDTH)) bus ();

`ifdef L1_MERGE_PERF_EN
    logic [31:0] perf_i, perf_d;
    vx_l1_mem_merge dut (.clk(clk), .reset(reset), .bus(bus),
                         .perf_icache_stalls(perf_i), .perf_dcache_stalls(perf_d));
`else
    vx_l1_mem_merge dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    typedef struct {
        logic iv; logic dv; logic drw;
        logic exp_ir; logic exp_dr; logic exp_mv;
        logic [8:0] exp_tag; logic exp_rw; logic [25:0] exp_addr;
    } req_vec_t;

    typedef struct {
        logic rv; logic [8:0] tag; logic ir; logic dr;
        logic exp_iv; logic exp_dv; logic [7:0] exp_tag; logic exp_mr;
    } rsp_vec_t;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.icache_req_valid  = 1'b0;
        bus.icache_req_addr   = IADDR;
        bus.icache_req_tag    = ITAG;
        bus.dcache_req_valid  = 1'b0;
        bus.dcache_req_rw     = 1'b0;
        bus.dcache_req_addr   = DADDR;
        bus.dcache_req_data   = DDATA;
        bus.dcache_req_byteen = DBE;
        bus.dcache_req_tag    = DTAG;
        bus.mem_req_ready     = 1'b1;
        bus.mem_rsp_valid     = 1'b0;
        bus.mem_rsp_data      = RDATA;
        bus.mem_rsp_tag       = 9'h0;
        bus.icache_rsp_ready  = 1'b0;
        bus.dcache_rsp_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    req_vec_t rq [6];
    rsp_vec_t rs [5];

    initial begin
        rq[0] = '{1,0,0, 1,0,1, 9'h03C,0,IADDR};
        rq[1] = '{0,1,1, 0,1,1, 9'h1A5,1,DADDR};
        rq[2] = '{1,1,0, 1,0,1, 9'h03C,0,IADDR};
        rq[3] = '{0,0,0, 0,0,0, 9'h000,0,IADDR};
        rq[4] = '{1,1,1, 1,0,1, 9'h03C,0,IADDR};
        rq[5] = '{0,1,0, 0,1,1, 9'h1A5,0,DADDR};

        rs[0] = '{1, 9'h105, 1, 0, 0, 1, 8'h05, 0};
        rs[1] = '{1, 9'h105, 0, 1, 0, 1, 8'h05, 1};
        rs[2] = '{1, 9'h07F, 1, 0, 1, 0, 8'h7F, 1};
        rs[3] = '{1, 9'h07F, 0, 1, 1, 0, 8'h7F, 0};
        rs[4] = '{0, 9'h1FF, 1, 1, 0, 0, 8'hFF, 1};

        do_reset();
        chk("reset_mem_req_valid", bus.mem_req_valid, 0);
        chk("reset_pending", dut.pending_q, 0);
        chk("reset_starve", dut.starve_q, 0);

        // request path vectors, one per cycle, downstream always ready
        for (int k = 0; k < 6; k++) begin
            bus.icache_req_valid = rq[k].iv;
            bus.dcache_req_valid = rq[k].dv;
            bus.dcache_req_rw    = rq[k].drw;
            #3;
            chk($sformatf("vec%0d_icache_ready", k), bus.icache_req_ready, rq[k].exp_ir);
            chk($sformatf("vec%0d_dcache_ready", k), bus.dcache_req_ready, rq[k].exp_dr);
            #1;
            step();
            idle_inputs();
            chk($sformatf("vec%0d_mem_valid", k), bus.mem_req_valid, rq[k].exp_mv);
            if (rq[k].exp_mv) begin
                chk($sformatf("vec%0d_tag", k), bus.mem_req_tag, rq[k].exp_tag);
                chk($sformatf("vec%0d_rw", k), bus.mem_req_rw, rq[k].exp_rw);
                chk($sformatf("vec%0d_addr", k), bus.mem_req_addr, rq[k].exp_addr);
                chk($sformatf("vec%0d_data", k), bus.mem_req_data,
                    rq[k].exp_tag[8] ? DDATA : 512'h0);
                chk($sformatf("vec%0d_byteen", k), bus.mem_req_byteen,
                    rq[k].exp_tag[8] ? {448'h0, DBE} : {448'h0, {64{1'b1}}});
            end
        end
        chk("vec_pending", dut.pending_q, 4);

        // response routing vectors: applied and removed between clock edges
        for (int k = 0; k < 5; k++) begin
            bus.mem_rsp_valid    = rs[k].rv;
            bus.mem_rsp_tag      = rs[k].tag;
            bus.icache_rsp_ready = rs[k].ir;
            bus.dcache_rsp_ready = rs[k].dr;
            #3;
            chk($sformatf("rsp%0d_icache_valid", k), bus.icache_rsp_valid, rs[k].exp_iv);
            chk($sformatf("rsp%0d_dcache_valid", k), bus.dcache_rsp_valid, rs[k].exp_dv);
            chk($sformatf("rsp%0d_icache_tag", k), bus.icache_rsp_tag, rs[k].exp_tag);
            chk($sformatf("rsp%0d_dcache_tag", k), bus.dcache_rsp_tag, rs[k].exp_tag);
            chk($sformatf("rsp%0d_mem_rsp_ready", k), bus.mem_rsp_ready, rs[k].exp_mr);
            chk($sformatf("rsp%0d_data", k), bus.icache_rsp_data, RDATA);
            #2;
            idle_inputs();
            step();
        end

        // starvation pattern I,I,I,I,D repeating
        do_reset();
        bus.icache_req_valid = 1'b1;
        bus.dcache_req_valid = 1'b1;
        bus.dcache_req_rw    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #3;
            chk($sformatf("starve%0d_icache_grant", k), bus.icache_req_ready, (k % 5) != 4);
            chk($sformatf("starve%0d_dcache_grant", k), bus.dcache_req_ready, (k % 5) == 4);
            step();
        end
        idle_inputs();

        // pending limit: 16 reads outstanding, write passes, one response frees a slot
        do_reset();
        bus.icache_req_valid = 1'b1;
        for (int k = 0; k < 16; k++) step();
        chk("limit_pending16", dut.pending_q, 16);
        bus.dcache_req_valid = 1'b1;
        bus.dcache_req_rw    = 1'b1;
        #3;
        chk("limit_icache_held", bus.icache_req_ready, 0);
        chk("limit_write_accepted", bus.dcache_req_ready, 1);
        step();
        chk("limit_write_tag", bus.mem_req_tag, 9'h1A5);
        chk("limit_write_rw", bus.mem_req_rw, 1);
        bus.dcache_req_valid = 1'b0;
        bus.mem_rsp_valid    = 1'b1;
        bus.mem_rsp_tag      = 9'h03C;
        bus.icache_rsp_ready = 1'b1;
        #3;
        chk("limit_rsp_ready", bus.mem_rsp_ready, 1);
        chk("limit_icache_still_held", bus.icache_req_ready, 0);
        step();
        bus.mem_rsp_valid = 1'b0;
        #3;
        chk("limit_icache_after_rsp", bus.icache_req_ready, 1);
        chk("limit_pending15", dut.pending_q, 15);
        step();
        chk("limit_pending_refill", dut.pending_q, 16);
        idle_inputs();

        // backpressure: full register held stable for 5 cycles, then drain+accept
        do_reset();
        bus.mem_req_ready    = 1'b0;
        bus.icache_req_valid = 1'b1;
        #3;
        chk("bp_fill_ready", bus.icache_req_ready, 1);
        step();
        bus.icache_req_tag   = 8'h77;
        bus.icache_req_addr  = 26'h0000111;
        bus.dcache_req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #3;
            chk($sformatf("bp%0d_icache_ready", k), bus.icache_req_ready, 0);
            chk($sformatf("bp%0d_dcache_ready", k), bus.dcache_req_ready, 0);
            chk($sformatf("bp%0d_valid", k), bus.mem_req_valid, 1);
            chk($sformatf("bp%0d_tag", k), bus.mem_req_tag, 9'h03C);
            chk($sformatf("bp%0d_addr", k), bus.mem_req_addr, IADDR);
            step();
        end
        chk("bp_starve_held", dut.starve_q, 0);
        bus.mem_req_ready = 1'b1;
        #3;
        chk("bp_drain_accept", bus.icache_req_ready, 1);
        step();
        chk("bp_new_tag", bus.mem_req_tag, 9'h077);
        chk("bp_new_addr", bus.mem_req_addr, 26'h0000111);
        chk("bp_starve_after", dut.starve_q, 1);
        idle_inputs();

        // asynchronous reset with 7 reads outstanding
        do_reset();
        bus.icache_req_valid = 1'b1;
        for (int k = 0; k < 7; k++) step();
        bus.icache_req_valid = 1'b0;
        bus.mem_req_ready    = 1'b0;
        chk("arst_pending7", dut.pending_q, 7);
        chk("arst_valid_before", bus.mem_req_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid_cleared", bus.mem_req_valid, 0);
        chk("arst_pending_cleared", dut.pending_q, 0);
        step();
        reset = 1'b0;
        idle_inputs();

`ifdef L1_MERGE_PERF_EN
        do_reset();
        chk("perf_reset", perf_i, 0);
        bus.mem_req_ready    = 1'b0;
        bus.icache_req_valid = 1'b1;
        step();
        for (int k = 0; k < 3; k++) step();
        bus.icache_req_valid = 1'b0;
        step();
        chk("perf_icache_stalls", perf_i, 3);
        chk("perf_dcache_stalls", perf_d, 0);
        idle_inputs();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
